// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_pkg
// Description : Shared state encoding and helpers for the SAR search engine.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_search_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_TRIAL  = 2'd1;
    localparam logic [1:0] c_ST_VERIFY = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_TRIAL  = c_ST_TRIAL,
        ST_VERIFY = c_ST_VERIFY,
        ST_DONE   = c_ST_DONE
    } state_t;

    // One-hot word with only bit (w-1) set; callers size-cast to their width.
    function automatic logic [31:0] msb_onehot(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_trial_timer.sv
`default_nettype none
// ============================================================================
// Module      : sar_trial_timer
// Description : Per-trial comparator settle down-counter with load and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_trial_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] c_RELOAD = CW'(SETTLE);

    logic [CW-1:0] r_cnt;

    // Load wins over decrement so a new trial always starts from a full count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_ctrl
// Description : Successive-approximation search driving an external comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search_ctrl
    import sar_search_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_cmp_gt,
    input  logic             i_cmp_eq,
    output logic [WIDTH-1:0] o_guess,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_found
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0]    c_IDX_TOP = IW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MSB     = WIDTH'(msb_onehot(WIDTH));

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_guess, w_guess_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_found, w_found_nxt;
    logic [IW-1:0]    r_bit_idx, w_bit_idx_nxt;
    logic             w_load;
    logic             w_timer_en;
    logic             w_settled;

    assign w_timer_en = (r_state == ST_TRIAL) || (r_state == ST_VERIFY);

    sar_trial_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_timer_en),
        .o_zero (w_settled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_guess   <= '0;
            r_result  <= '0;
            r_found   <= 1'b0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_guess   <= w_guess_nxt;
            r_result  <= w_result_nxt;
            r_found   <= w_found_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_guess_nxt   = r_guess;
        w_result_nxt  = r_result;
        w_found_nxt   = r_found;
        w_bit_idx_nxt = r_bit_idx;
        w_load        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = ST_TRIAL;
                    w_guess_nxt   = c_MSB;
                    w_bit_idx_nxt = c_IDX_TOP;
                    w_load        = 1'b1;
                end
            end
            ST_TRIAL: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settled) begin
                    if (i_cmp_eq) begin
                        w_result_nxt = r_guess;
                        w_found_nxt  = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        if (i_cmp_gt) begin
                            w_guess_nxt[r_bit_idx] = 1'b0;
                        end
                        w_load = 1'b1;
                        if (r_bit_idx != '0) begin
                            w_guess_nxt[r_bit_idx - IW'(1)] = 1'b1;
                            w_bit_idx_nxt = r_bit_idx - IW'(1);
                        end else begin
                            // Bit 0 resolved; one more trial confirms equality.
                            w_state_nxt = ST_VERIFY;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_settled) begin
                    w_result_nxt = r_guess;
                    w_found_nxt  = i_cmp_eq;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_guess  = r_guess;
    assign o_busy   = w_timer_en;
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_result;
    assign o_found  = r_found;

endmodule
`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search_ctrl
// Description : Directed self-checking bench for sar_search_ctrl (WIDTH=8, SETTLE=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search_ctrl;

    localparam int WIDTH  = 8;
    localparam int SETTLE = 1;

    logic             clk;
    logic             rst_n;
    logic             r_start;
    logic             r_abort;
    logic             w_cmp_gt;
    logic             w_cmp_eq;
    logic [WIDTH-1:0] w_guess;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_result;
    logic             w_found;

    logic [WIDTH-1:0] r_target;
    logic             r_faulty;

    int n_tests;
    int n_fail;

    sar_search_ctrl #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (r_start),
        .i_abort  (r_abort),
        .i_cmp_gt (w_cmp_gt),
        .i_cmp_eq (w_cmp_eq),
        .o_guess  (w_guess),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_result (w_result),
        .o_found  (w_found)
    );

    // Comparator model; the faulty variant has both outputs stuck low.
    assign w_cmp_gt = r_faulty ? 1'b0 : (w_guess > r_target);
    assign w_cmp_eq = r_faulty ? 1'b0 : (w_guess == r_target);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        r_start = 1'b1;
        @(posedge clk);
        #1;
        r_start = 1'b0;
    endtask

    // Runs one full search; records every distinct guess presented.
    task automatic run_search(input string tag, input logic [WIDTH-1:0] t, input logic faulty,
                              input logic [WIDTH-1:0] exp_res, input logic exp_found,
                              input int exp_cyc, output logic [63:0] seq, output int n_seq);
        int cyc;
        logic [WIDTH-1:0] last;
        r_target = t;
        r_faulty = faulty;
        pulse_start();
        seq   = '0;
        last  = w_guess;
        seq   = {seq[55:0], w_guess};
        n_seq = 1;
        cyc   = 0;
        while (cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (w_done) break;
            if (w_guess != last) begin
                last  = w_guess;
                seq   = {seq[55:0], w_guess};
                n_seq = n_seq + 1;
            end
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_done"},    {31'd0, w_done}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, w_busy}, 32'd0);
        chk({tag, "_result"},  {24'd0, w_result}, {24'd0, exp_res});
        chk({tag, "_found"},   {31'd0, w_found}, {31'd0, exp_found});
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, w_done}, 32'd0);
    endtask

    initial begin
        logic [63:0] seq;
        int          n_seq;
        int          done_seen;

        n_tests  = 0;
        n_fail   = 0;
        r_start  = 1'b0;
        r_abort  = 1'b0;
        r_target = '0;
        r_faulty = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_guess",  {24'd0, w_guess},  32'd0);
        chk("rst_busy",   {31'd0, w_busy},   32'd0);
        chk("rst_done",   {31'd0, w_done},   32'd0);
        chk("rst_result", {24'd0, w_result}, 32'd0);
        chk("rst_found",  {31'd0, w_found},  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_search("t80", 8'h80, 1'b0, 8'h80, 1'b1, 2, seq, n_seq);
        chk("t80_first_guess", {24'd0, seq[7:0]}, 32'h80);

        run_search("t37", 8'h37, 1'b0, 8'h37, 1'b1, 16, seq, n_seq);
        chk("t37_nguess", n_seq, 8);
        chk("t37_seq_hi", seq[63:32], 32'h80402030);
        chk("t37_seq_lo", seq[31:0],  32'h38343637);

        run_search("t00", 8'h00, 1'b0, 8'h00, 1'b1, 18, seq, n_seq);

        run_search("faulty", 8'h00, 1'b1, 8'hFF, 1'b0, 18, seq, n_seq);
        chk("faulty_guess_end", {24'd0, w_guess}, 32'hFF);

        // Abort on cycle 5 of a search; previous result/found must survive.
        r_target = 8'h37;
        r_faulty = 1'b0;
        pulse_start();
        repeat (4) @(posedge clk);
        #1;
        r_abort = 1'b1;
        @(posedge clk);
        #1;
        r_abort = 1'b0;
        chk("abort_busy", {31'd0, w_busy}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (w_done) done_seen++;
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_result", {24'd0, w_result}, 32'hFF);
        chk("abort_found",  {31'd0, w_found},  32'd0);
        run_search("restart", 8'h37, 1'b0, 8'h37, 1'b1, 16, seq, n_seq);

        // Asynchronous reset in the middle of cycle 7 of a search.
        r_target = 8'h37;
        pulse_start();
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_guess",  {24'd0, w_guess},  32'd0);
        chk("mid_rst_busy",   {31'd0, w_busy},   32'd0);
        chk("mid_rst_done",   {31'd0, w_done},   32'd0);
        chk("mid_rst_result", {24'd0, w_result}, 32'd0);
        chk("mid_rst_found",  {31'd0, w_found},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_search("after_rst", 8'h55, 1'b0, 8'h55, 1'b1, 16, seq, n_seq);
        chk("after_rst_seq_lo", seq[31:0], 32'h58545655);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
